// File: rtl/sr_reg_bank.sv
// sr_reg_bank: clocked bank of WIDTH set/reset flags with optional input
// synchronisers, a selectable set/reset collision policy, edge pulses,
// sticky per-channel conflict flags and a registered population count.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   en       global update enable (sampled directly, not synchronised)
//   s, r     per-channel set / reset requests (WIDTH)
//   clr_err  clears all conflict bits
//   q, q_    flag state and its complement (WIDTH)
//   rise     one-cycle pulse on a q 0->1 change (WIDTH)
//   fall     one-cycle pulse on a q 1->0 change (WIDTH)
//   conflict sticky: s and r resolved high together while en was high
//   cnt      registered popcount of q, one cycle behind q

// Per-channel slice: synchroniser chains, flag, delayed flag, conflict bit.
module sr_reg_bank_lane #(
  parameter int   MODE        = 0,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_BIT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic s_i,
  input  logic r_i,
  input  logic clr_err_i,
  output logic q_o,
  output logic qd_o,
  output logic conflict_o
);
  logic ss, rs;
  logic q_q, q_d, qd_q;
  logic conflict_q, conflict_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ss = s_i;
      assign rs = r_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] s_sync_q, r_sync_q;
      // Chains shift every cycle regardless of en.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_sync_q <= '0;
          r_sync_q <= '0;
        end else begin
          s_sync_q[0] <= s_i;
          r_sync_q[0] <= r_i;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            s_sync_q[k] <= s_sync_q[k-1];
            r_sync_q[k] <= r_sync_q[k-1];
          end
        end
      end
      assign ss = s_sync_q[SYNC_STAGES-1];
      assign rs = r_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      unique case ({ss, rs})
        2'b10:   q_d = 1'b1;
        2'b01:   q_d = 1'b0;
        2'b11: begin
          case (MODE)
            0:       q_d = 1'b1;
            1:       q_d = 1'b0;
            2:       q_d = q_q;
            default: q_d = ~q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // A fresh collision outranks a same-cycle clear.
  assign conflict_d = (en_i & ss & rs) | (conflict_q & ~clr_err_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= INIT_BIT;
      qd_q       <= INIT_BIT;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qd_q       <= q_q;
      conflict_q <= conflict_d;
    end
  end

  assign q_o        = q_q;
  assign qd_o       = qd_q;
  assign conflict_o = conflict_q;
endmodule

module sr_reg_bank #(
  parameter int               WIDTH       = 8,
  parameter int               MODE        = 0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           s,
  input  logic [WIDTH-1:0]           r,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_,
  output logic [WIDTH-1:0]           rise,
  output logic [WIDTH-1:0]           fall,
  output logic [WIDTH-1:0]           conflict,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);
  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] q_q, qd_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) sum = sum + CW'(v[i]);
    return sum;
  endfunction

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      sr_reg_bank_lane #(
        .MODE        (MODE),
        .SYNC_STAGES (SYNC_STAGES),
        .INIT_BIT    (INIT[i])
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .s_i        (s[i]),
        .r_i        (r[i]),
        .clr_err_i  (clr_err),
        .q_o        (q_q[i]),
        .qd_o       (qd_q[i]),
        .conflict_o (conflict[i])
      );
    end
  endgenerate

  assign cnt_d = popcount(q_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= popcount(INIT);
    else     cnt_q <= cnt_d;
  end

  // Complement is derived, never stored, so it tracks q even in reset.
  assign q    = q_q;
  assign q_   = ~q_q;
  assign rise = q_q & ~qd_q;
  assign fall = ~q_q & qd_q;
  assign cnt  = cnt_q;
endmodule

// File: tb/tb_sr_reg_bank.sv
// Self-checking bench for sr_reg_bank. Six instances:
//   sel 0     : MODE 0, SYNC_STAGES 2 (reset/latency, enable gating, conflict)
//   sel 1..4  : MODE 0..3, SYNC_STAGES 0 (collision policy sweep)
//   sel 5     : MODE 3, SYNC_STAGES 1 (continuous toggle)
module tb_sr_reg_bank;
  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] q, rise, fall, conf;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    string      tag;
    logic       en;
    logic [7:0] s, r;
    logic       clr;
    logic [7:0] q, rise, fall, conf;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en_a = 0, clr_a = 0, en_m = 0, clr_m = 0, en_t = 0, clr_t = 0;
  logic [7:0] s_a = 0, r_a = 0, s_m = 0, r_m = 0, s_t = 0, r_t = 0;

  logic [7:0] q_o [6], qn_o [6], rise_o [6], fall_o [6], conf_o [6];
  logic [3:0] cnt_o [6];

  sr_reg_bank #(.WIDTH(8), .MODE(0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .s(s_a), .r(r_a), .clr_err(clr_a),
    .q(q_o[0]), .q_(qn_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
    .conflict(conf_o[0]), .cnt(cnt_o[0]));

  generate
    for (genvar m = 0; m < 4; m++) begin : g_m
      sr_reg_bank #(.WIDTH(8), .MODE(m), .SYNC_STAGES(0)) u_m (
        .clk(clk), .rst(rst), .en(en_m), .s(s_m), .r(r_m), .clr_err(clr_m),
        .q(q_o[m+1]), .q_(qn_o[m+1]), .rise(rise_o[m+1]), .fall(fall_o[m+1]),
        .conflict(conf_o[m+1]), .cnt(cnt_o[m+1]));
    end
  endgenerate

  sr_reg_bank #(.WIDTH(8), .MODE(3), .SYNC_STAGES(1)) u_t (
    .clk(clk), .rst(rst), .en(en_t), .s(s_t), .r(r_t), .clr_err(clr_t),
    .q(q_o[5]), .q_(qn_o[5]), .rise(rise_o[5]), .fall(fall_o[5]),
    .conflict(conf_o[5]), .cnt(cnt_o[5]));

  exp_t sb [$];
  vec_t tab [$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(string tag, int sel, logic [7:0] q, rise, fall,
                              conf, logic [3:0] cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.q = q; e.rise = rise; e.fall = fall;
    e.conf = conf; e.cnt = cnt;
    return e;
  endfunction

  task automatic add(string tag, logic en, logic [7:0] s, r, logic clr,
                     logic [7:0] q, rise, fall, conf, logic [3:0] cnt);
    vec_t v;
    v.tag = tag; v.en = en; v.s = s; v.r = r; v.clr = clr;
    v.q = q; v.rise = rise; v.fall = fall; v.conf = conf; v.cnt = cnt;
    tab.push_back(v);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, req);
    end
  endtask

  task automatic cmp(exp_t e);
    chk({e.tag, ".q"},        q_o[e.sel],    e.q);
    chk({e.tag, ".q_"},       qn_o[e.sel],   ~e.q);
    chk({e.tag, ".rise"},     rise_o[e.sel], e.rise);
    chk({e.tag, ".fall"},     fall_o[e.sel], e.fall);
    chk({e.tag, ".conflict"}, conf_o[e.sel], e.conf);
    chk({e.tag, ".cnt"},      {4'h0, cnt_o[e.sel]}, {4'h0, e.cnt});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e);
    end
  endtask

  // Entered at a negedge: drive, queue expectation, cross one posedge,
  // compare at the following negedge.
  task automatic run_tab(int sel);
    vec_t v;
    while (tab.size() > 0) begin
      v = tab.pop_front();
      if (sel == 0) begin en_a = v.en; s_a = v.s; r_a = v.r; clr_a = v.clr; end
      else          begin en_t = v.en; s_t = v.s; r_t = v.r; clr_t = v.clr; end
      sb.push_back(mk(v.tag, sel, v.q, v.rise, v.fall, v.conf, v.cnt));
      @(negedge clk);
      drain();
    end
  endtask

  task automatic mstep(string tag, logic en, logic [7:0] s, r,
                       logic [3:0][7:0] eq, er, ef, logic [7:0] ec,
                       logic [3:0][3:0] en_cnt);
    en_m = en; s_m = s; r_m = r; clr_m = 1'b0;
    for (int m = 0; m < 4; m++)
      sb.push_back(mk($sformatf("%s.m%0d", tag, m), m + 1, eq[m], er[m],
                      ef[m], ec, en_cnt[m]));
    @(negedge clk);
    drain();
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 cmp(mk("rst0", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reach a non-reset state before the mid-run reset.
    add("a_s0", 1, 8'hF0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("a_s1", 1, 8'hF0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("a_s2", 1, 8'hF0, 8'h00, 0, 8'hF0, 8'hF0, 8'h00, 8'h00, 4'd0);
    add("a_s3", 1, 8'h00, 8'h00, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 4'd4);
    run_tab(0);

    // Mid-run reset with s already present; it must wait out the chain.
    s_a = 8'h05; en_a = 1'b1;
    rst = 1'b1;
    #1 cmp(mk("rst_mid", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
    @(negedge clk);
    cmp(mk("rst_hold", 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0));
    rst = 1'b0;

    add("lat0", 1, 8'h05, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("lat1", 1, 8'h05, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("lat2", 1, 8'h05, 8'h00, 0, 8'h05, 8'h05, 8'h00, 8'h00, 4'd0);
    add("lat3", 1, 8'h05, 8'h00, 0, 8'h05, 8'h00, 8'h00, 8'h00, 4'd2);
    add("lat4", 1, 8'h05, 8'h00, 0, 8'h05, 8'h00, 8'h00, 8'h00, 4'd2);
    // Enable gating.
    add("en0",  1, 8'hFF, 8'h00, 0, 8'h05, 8'h00, 8'h00, 8'h00, 4'd2);
    add("en1",  1, 8'hFF, 8'h00, 0, 8'h05, 8'h00, 8'h00, 8'h00, 4'd2);
    add("en2",  1, 8'hFF, 8'h00, 0, 8'hFF, 8'hFA, 8'h00, 8'h00, 4'd2);
    for (int i = 0; i < 5; i++)
      add($sformatf("en_off%0d", i), 0, 8'h00, 8'hFF, 0,
          8'hFF, 8'h00, 8'h00, 8'h00, 4'd8);
    add("en_on0", 1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 4'd8);
    add("en_on1", 1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    // Conflict stickiness and clear priority.
    add("cf0",  1, 8'h04, 8'h04, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("cf1",  1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("cf2",  1, 8'h00, 8'h00, 0, 8'h04, 8'h04, 8'h00, 8'h04, 4'd0);
    add("cf3",  1, 8'h00, 8'h00, 0, 8'h04, 8'h00, 8'h00, 8'h04, 4'd1);
    add("cf4",  1, 8'h00, 8'h00, 0, 8'h04, 8'h00, 8'h00, 8'h04, 4'd1);
    add("cf5",  1, 8'h00, 8'h00, 1, 8'h04, 8'h00, 8'h00, 8'h00, 4'd1);
    add("cf6",  1, 8'h04, 8'h04, 0, 8'h04, 8'h00, 8'h00, 8'h00, 4'd1);
    add("cf7",  1, 8'h00, 8'h00, 0, 8'h04, 8'h00, 8'h00, 8'h00, 4'd1);
    add("cf8",  1, 8'h00, 8'h00, 1, 8'h04, 8'h00, 8'h00, 8'h04, 4'd1);
    add("cf9",  1, 8'h00, 8'h00, 0, 8'h04, 8'h00, 8'h00, 8'h04, 4'd1);
    add("cf10", 1, 8'h00, 8'h00, 1, 8'h04, 8'h00, 8'h00, 8'h00, 4'd1);
    run_tab(0);

    // Collision policy sweep, no synchroniser. Index m of each packed
    // argument is the expectation for MODE m.
    mstep("ms_set", 1, 8'h0F, 8'h00,
          {8'h0F, 8'h0F, 8'h0F, 8'h0F}, {8'h0F, 8'h0F, 8'h0F, 8'h0F},
          {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, {4'd0, 4'd0, 4'd0, 4'd0});
    mstep("ms_col", 1, 8'h3C, 8'h3C,
          {8'h33, 8'h0F, 8'h03, 8'h3F}, {8'h30, 8'h00, 8'h00, 8'h30},
          {8'h0C, 8'h00, 8'h0C, 8'h00}, 8'h3C, {4'd4, 4'd4, 4'd4, 4'd4});
    mstep("ms_idle", 1, 8'h00, 8'h00,
          {8'h33, 8'h0F, 8'h03, 8'h3F}, {8'h00, 8'h00, 8'h00, 8'h00},
          {8'h00, 8'h00, 8'h00, 8'h00}, 8'h3C, {4'd4, 4'd4, 4'd2, 4'd6});
    mstep("ms_off", 0, 8'hFF, 8'hFF,
          {8'h33, 8'h0F, 8'h03, 8'h3F}, {8'h00, 8'h00, 8'h00, 8'h00},
          {8'h00, 8'h00, 8'h00, 8'h00}, 8'h3C, {4'd4, 4'd4, 4'd2, 4'd6});

    // MODE 3 continuous toggle with one synchroniser stage.
    add("tg0", 1, 8'h01, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add("tg1", 1, 8'h01, 8'h01, 0, 8'h01, 8'h01, 8'h00, 8'h01, 4'd0);
    add("tg2", 1, 8'h01, 8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h01, 4'd1);
    add("tg3", 1, 8'h01, 8'h01, 0, 8'h01, 8'h01, 8'h00, 8'h01, 4'd0);
    add("tg4", 1, 8'h01, 8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h01, 4'd1);
    add("tg5", 1, 8'h01, 8'h01, 0, 8'h01, 8'h01, 8'h00, 8'h01, 4'd0);
    add("tg6", 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h01, 4'd1);
    add("tg7", 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h01, 4'd0);
    run_tab(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
